// File: rtl/axi_mem_pkg.sv
// Shared constants, FSM state types and beat-address helpers for the AXI memory responder.
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } rd_state_t;

    // FIXED holds; INCR, WRAP and reserved all step linearly. Caller truncates to its address width.
    function automatic logic [63:0] next_beat_addr(input logic [63:0] addr,
                                                   input logic [1:0]  burst,
                                                   input logic [63:0] step);
        return (burst == BURST_FIXED) ? addr : addr + step;
    endfunction

    // Encodings are ordered so the numerically larger code is the more severe one.
    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Simple dual-port word array: byte-enabled write on port A, registered read on port B (read-first).
module axi_mem_array #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                    clk,
    input  logic                    a_we,
    input  logic [DEPTH_LOG2-1:0]   a_addr,
    input  logic [DATA_WIDTH/8-1:0] a_strb,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    input  logic                    b_re,
    input  logic [DEPTH_LOG2-1:0]   b_addr,
    output logic [DATA_WIDTH-1:0]   b_rdata
);
    localparam int NB = DATA_WIDTH / 8;

    logic [NB-1:0][7:0] mem [2**DEPTH_LOG2];
    logic [NB-1:0][7:0] wbytes;

    assign wbytes = a_wdata;

    // Both ports update with non-blocking assigns, so a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (a_we) begin
            for (int i = 0; i < NB; i++) begin
                if (a_strb[i]) mem[a_addr][i] <= wbytes[i];
            end
        end
        if (b_re) b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model with independent single-outstanding read and write FSMs.
// Optional AXI_MEM_RAND_STALL_EN adds LFSR-driven ready gating and response delays.
import axi_mem_pkg::*;

module axi_mem_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int ID_WIDTH       = 1,
    parameter int MEM_DEPTH_LOG2 = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast
);
    localparam int         NB        = DATA_WIDTH / 8;
    localparam int         OFF       = $clog2(NB);
    localparam logic [2:0] FULL_SIZE = 3'(OFF);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (MEM_DEPTH_LOG2 + OFF)) == '0;
    endfunction

    function automatic logic [MEM_DEPTH_LOG2-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[OFF +: MEM_DEPTH_LOG2];
    endfunction

    // Burst-wide error known at address time: size mismatch or non-INCR/FIXED burst type.
    function automatic logic [1:0] hdr_resp(input logic [2:0] size, input logic [1:0] burst);
        return (size != FULL_SIZE || burst == BURST_WRAP || burst == 2'b11) ? RESP_SLVERR : RESP_OKAY;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [1:0] burst);
        return ADDR_WIDTH'(next_beat_addr(64'(a), burst, 64'(NB)));
    endfunction

    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;

    logic aw_gate, w_gate, ar_gate;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // ---------------- stall generation ----------------
`ifdef AXI_MEM_RAND_STALL_EN
    logic [15:0] lfsr;
    logic        b_held, r_held;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr   <= 16'hACE1;
            b_held <= 1'b0;
            r_held <= 1'b0;
        end else begin
            lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            b_held <= s_axi_bvalid && !s_axi_bready;
            r_held <= s_axi_rvalid && !s_axi_rready;
        end
    end

    assign aw_gate      = lfsr[0];
    assign w_gate       = lfsr[3];
    assign ar_gate      = lfsr[6];
    assign s_axi_bvalid = (w_state == W_RESP) && (b_held || lfsr[9]);
    assign s_axi_rvalid = (r_state == R_DATA) && (r_held || lfsr[12]);
`else
    assign aw_gate      = 1'b1;
    assign w_gate       = 1'b1;
    assign ar_gate      = 1'b1;
    assign s_axi_bvalid = (w_state == W_RESP);
    assign s_axi_rvalid = (r_state == R_DATA);
`endif

    assign s_axi_awready = (w_state == W_IDLE) && aw_gate;
    assign s_axi_wready  = (w_state == W_DATA) && w_gate;
    assign s_axi_arready = (r_state == R_IDLE) && ar_gate;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid  && s_axi_wready;
    assign b_hs  = s_axi_bvalid  && s_axi_bready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid  && s_axi_rready;

    // ---------------- write channel ----------------
    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len, w_cnt;
    logic [1:0]            aw_burst, w_err, w_beat_resp, w_err_nxt;
    logic                  w_last_exp;

    assign w_last_exp  = (w_cnt == aw_len);
    assign w_beat_resp = !in_range(aw_addr)            ? RESP_DECERR :
                         (s_axi_wlast != w_last_exp)   ? RESP_SLVERR : RESP_OKAY;
    assign w_err_nxt   = worst_resp(w_err, w_beat_resp);

    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_last_exp) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_id       <= '0;
            aw_addr     <= '0;
            aw_len      <= '0;
            aw_burst    <= BURST_INCR;
            w_cnt       <= '0;
            w_err       <= RESP_OKAY;
            s_axi_bid   <= '0;
            s_axi_bresp <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_id    <= s_axi_awid;
                aw_addr  <= s_axi_awaddr;
                aw_len   <= s_axi_awlen;
                aw_burst <= s_axi_awburst;
                w_cnt    <= '0;
                w_err    <= hdr_resp(s_axi_awsize, s_axi_awburst);
            end
            if (w_hs) begin
                w_cnt   <= w_cnt + 8'd1;
                aw_addr <= step_addr(aw_addr, aw_burst);
                w_err   <= w_err_nxt;
                if (w_last_exp) begin
                    s_axi_bid   <= aw_id;
                    s_axi_bresp <= w_err_nxt;
                end
            end
        end
    end

    // ---------------- read channel ----------------
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len, r_cnt;
    logic [1:0]            ar_burst, r_hdr, r_resp_q;
    logic                  r_last_q;
    logic [DATA_WIDTH-1:0] ram_q;

    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_FETCH;
            R_FETCH: r_next = R_DATA;
            R_DATA:  if (r_hs) r_next = r_last_q ? R_IDLE : R_FETCH;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_axi_rid <= '0;
            ar_addr   <= '0;
            ar_len    <= '0;
            ar_burst  <= BURST_INCR;
            r_cnt     <= '0;
            r_hdr     <= RESP_OKAY;
            r_resp_q  <= RESP_OKAY;
            r_last_q  <= 1'b0;
        end else begin
            if (ar_hs) begin
                s_axi_rid <= s_axi_arid;
                ar_addr   <= s_axi_araddr;
                ar_len    <= s_axi_arlen;
                ar_burst  <= s_axi_arburst;
                r_cnt     <= '0;
                r_hdr     <= hdr_resp(s_axi_arsize, s_axi_arburst);
            end
            if (r_state == R_FETCH) begin
                r_resp_q <= in_range(ar_addr) ? r_hdr : RESP_DECERR;
                r_last_q <= (r_cnt == ar_len);
            end
            if (r_hs && !r_last_q) begin
                r_cnt   <= r_cnt + 8'd1;
                ar_addr <= step_addr(ar_addr, ar_burst);
            end
        end
    end

    // Beat fields are only presented in R_DATA; ram_q is stable there since reads issue only in R_FETCH.
    assign s_axi_rdata = (r_state == R_DATA && r_resp_q != RESP_DECERR) ? ram_q : '0;
    assign s_axi_rresp = (r_state == R_DATA) ? r_resp_q : RESP_OKAY;
    assign s_axi_rlast = (r_state == R_DATA) && r_last_q;

    axi_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (MEM_DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .a_we    (w_hs && in_range(aw_addr)),
        .a_addr  (word_idx(aw_addr)),
        .a_strb  (s_axi_wstrb),
        .a_wdata (s_axi_wdata),
        .b_re    (r_state == R_FETCH),
        .b_addr  (word_idx(ar_addr)),
        .b_rdata (ram_q)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder (default build, no random stalls).
module tb_axi_mem_responder;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 1;
    localparam int NB = DW / 8;
    localparam int BUDGET = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          awvalid, awready;
    logic [IW-1:0] awid;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          wvalid, wready;
    logic [DW-1:0] wdata;
    logic [NB-1:0] wstrb;
    logic          wlast;
    logic          bvalid, bready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          arvalid, arready;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          rvalid, rready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;

    int n_tests = 0;
    int n_fail  = 0;
    logic wr_done;

    always #5 clk = ~clk;

    axi_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH_LOG2(12)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awid(awid), .s_axi_awaddr(awaddr),
        .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bid(bid), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_arid(arid), .s_axi_araddr(araddr),
        .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rid(rid), .s_axi_rdata(rdata),
        .s_axi_rresp(rresp), .s_axi_rlast(rlast)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // All drivers change on negedge; a handshake completes on the posedge in between.
    task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int k = 0;
        awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (!awready && k < BUDGET) begin @(negedge clk); k++; end
        chk("tmo_aw", 64'(k < BUDGET), 64'd1);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [NB-1:0] s, input logic l);
        int k = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        while (!wready && k < BUDGET) begin @(negedge clk); k++; end
        chk("tmo_w", 64'(k < BUDGET), 64'd1);
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic recv_b(output logic [IW-1:0] id, output logic [1:0] resp);
        int k = 0;
        bready = 1'b1;
        while (!bvalid && k < BUDGET) begin @(negedge clk); k++; end
        chk("tmo_b", 64'(k < BUDGET), 64'd1);
        id = bid; resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int k = 0;
        arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        while (!arready && k < BUDGET) begin @(negedge clk); k++; end
        chk("tmo_ar", 64'(k < BUDGET), 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic recv_r(output logic [DW-1:0] d, output logic [1:0] resp, output logic l,
                          output logic [IW-1:0] id);
        int k = 0;
        rready = 1'b1;
        while (!rvalid && k < BUDGET) begin @(negedge clk); k++; end
        chk("tmo_r", 64'(k < BUDGET), 64'd1);
        d = rdata; resp = rresp; l = rlast; id = rid;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic wr_burst(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] a,
                            input logic [7:0] len, input logic [1:0] burst, input logic [DW-1:0] d0,
                            input logic [DW-1:0] dstep, input logic [NB-1:0] s, input int last_at,
                            input logic [1:0] eresp);
        logic [IW-1:0] gid;
        logic [1:0]    gresp;
        send_aw(id, a, len, 3'd3, burst);
        for (int i = 0; i <= int'(len); i++) send_w(d0 + dstep * 64'(i), s, i == last_at);
        recv_b(gid, gresp);
        chk({tag, "_bresp"}, 64'(gresp), 64'(eresp));
        chk({tag, "_bid"}, 64'(gid), 64'(id));
    endtask

    // Expected beat i data is e0 + estep*i.
    task automatic rd_beats(input string tag, input logic [7:0] len, input logic [DW-1:0] e0,
                            input logic [DW-1:0] estep, input logic [1:0] eresp, input logic [IW-1:0] eid);
        logic [DW-1:0] d;
        logic [1:0]    r;
        logic          l;
        logic [IW-1:0] id;
        for (int i = 0; i <= int'(len); i++) begin
            recv_r(d, r, l, id);
            chk($sformatf("%s_d%0d", tag, i), d, e0 + estep * 64'(i));
            chk($sformatf("%s_resp%0d", tag, i), 64'(r), 64'(eresp));
            chk($sformatf("%s_last%0d", tag, i), 64'(l), 64'(i == int'(len)));
            chk($sformatf("%s_id%0d", tag, i), 64'(id), 64'(eid));
        end
    endtask

    task automatic rd_burst(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] a,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                            input logic [DW-1:0] e0, input logic [DW-1:0] estep, input logic [1:0] eresp);
        send_ar(id, a, len, size, burst);
        rd_beats(tag, len, e0, estep, eresp, id);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
        wr_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        chk("rst_awready", 64'(awready), 64'd1);
        chk("rst_arready", 64'(arready), 64'd1);
        chk("rst_wready",  64'(wready),  64'd0);
        chk("rst_bvalid",  64'(bvalid),  64'd0);
        chk("rst_rvalid",  64'(rvalid),  64'd0);
        chk("rst_rlast",   64'(rlast),   64'd0);
        chk("rst_bresp",   64'(bresp),   64'd0);
        chk("rst_rresp",   64'(rresp),   64'd0);
        chk("rst_rdata",   rdata,        64'd0);

        // INCR burst write then read back, with first-beat latency
        wr_burst("incr_wr", 1'b0, 32'h100, 8'd3, 2'b01, 64'h11, 64'h11, 8'hFF, 3, 2'b00);
        send_ar(1'b0, 32'h100, 8'd3, 3'd3, 2'b01);
        k = 0;
        while (!rvalid && k < BUDGET) begin @(negedge clk); k++; end
        chk("rd_latency", 64'(k), 64'd1);
        rd_beats("incr_rd", 8'd3, 64'h11, 64'h11, 2'b00, 1'b0);

        // partial strobes
        wr_burst("strb_a", 1'b0, 32'h200, 8'd0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'hFF, 0, 2'b00);
        wr_burst("strb_b", 1'b0, 32'h200, 8'd0, 2'b01, 64'h0, 64'd0, 8'h0F, 0, 2'b00);
        rd_burst("strb_rd", 1'b0, 32'h200, 8'd0, 3'd3, 2'b01, 64'hFFFF_FFFF_0000_0000, 64'd0, 2'b00);

        // out-of-range: 0x8000 would alias word 0 if the upper bits were ignored
        wr_burst("w0_init", 1'b0, 32'h0, 8'd0, 2'b01, 64'h0123_4567_89AB_CDEF, 64'd0, 8'hFF, 0, 2'b00);
        rd_burst("oor_rd", 1'b0, 32'h8000, 8'd0, 3'd3, 2'b01, 64'd0, 64'd0, 2'b11);
        wr_burst("oor_wr", 1'b0, 32'h8000, 8'd0, 2'b01, 64'hDEAD_BEEF, 64'd0, 8'hFF, 0, 2'b11);
        rd_burst("w0_keep", 1'b0, 32'h0, 8'd0, 3'd3, 2'b01, 64'h0123_4567_89AB_CDEF, 64'd0, 2'b00);

        // early wlast: all four beats still taken, sticky SLVERR
        wr_burst("early_wlast", 1'b0, 32'h500, 8'd3, 2'b01, 64'hA0, 64'h1, 8'hFF, 1, 2'b10);
        rd_burst("early_rd", 1'b0, 32'h500, 8'd3, 3'd3, 2'b01, 64'hA0, 64'h1, 2'b00);

        // FIXED burst: both beats hit the same word
        wr_burst("fixed_wr", 1'b0, 32'h400, 8'd1, 2'b00, 64'h0A, 64'h0A, 8'hFF, 1, 2'b00);
        rd_burst("fixed_rd", 1'b0, 32'h400, 8'd1, 3'd3, 2'b00, 64'h14, 64'd0, 2'b00);

        // size mismatch and WRAP both flag SLVERR but still move full-width data
        rd_burst("size_rd", 1'b0, 32'h100, 8'd0, 3'd2, 2'b01, 64'h11, 64'd0, 2'b10);
        rd_burst("wrap_rd", 1'b0, 32'h100, 8'd1, 3'd3, 2'b10, 64'h11, 64'h11, 2'b10);

        // concurrent write (id 1) and stalled read (id 0)
        fork
            begin
                wr_burst("conc_wr", 1'b1, 32'h300, 8'd1, 2'b01, 64'h55, 64'h11, 8'hFF, 1, 2'b00);
                wr_done = 1'b1;
            end
            begin
                send_ar(1'b0, 32'h100, 8'd3, 3'd3, 2'b01);
                k = 0;
                while (!rvalid && k < BUDGET) begin @(negedge clk); k++; end
                for (int i = 0; i < 5; i++) begin
                    chk($sformatf("stall_vld%0d", i), 64'(rvalid), 64'd1);
                    chk($sformatf("stall_d%0d", i), rdata, 64'h11);
                    chk($sformatf("stall_last%0d", i), 64'(rlast), 64'd0);
                    @(negedge clk);
                end
                chk("conc_wr_done", 64'(wr_done), 64'd1);
                rd_beats("conc_rd", 8'd3, 64'h11, 64'h11, 2'b00, 1'b0);
            end
        join
        rd_burst("conc_chk", 1'b0, 32'h300, 8'd1, 3'd3, 2'b01, 64'h55, 64'h11, 2'b00);

        // reset in the middle of a read burst
        begin
            logic [DW-1:0] d;
            logic [1:0]    r;
            logic          l;
            logic [IW-1:0] id;
            send_ar(1'b0, 32'h100, 8'd3, 3'd3, 2'b01);
            recv_r(d, r, l, id);
            chk("mid_d0", d, 64'h11);
            rst = 1'b1;
            @(negedge clk);
            chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
            chk("mid_rst_arready", 64'(arready), 64'd1);
            rst = 1'b0;
            rd_burst("post_rst", 1'b0, 32'h108, 8'd0, 3'd3, 2'b01, 64'h22, 64'd0, 2'b00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
AXI4 slave memory model that terminates the DMA engine's master port (m_dma_axi_*) inside the emulation design.
- Accepts INCR/FIXED write and read bursts into a parameterised on-chip word array and returns B/R responses.
- Lets the DMA model close its loop without host memory.
- Read and write channels are served by independent FSMs, each with one transaction outstanding.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 64, AXI data width (power of two, >=32)
ID_WIDTH, 1, AXI ID width
MEM_DEPTH_LOG2, 12, log2 of word count of backing array

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
s_axi_awid  in  ID_WIDTH  write ID
s_axi_awaddr  in  ADDR_WIDTH  write start address
s_axi_awlen  in  8  beats-1
s_axi_awsize  in  3  beat size
s_axi_awburst  in  2  burst type
s_axi_wvalid / s_axi_wready  in/out  1  W handshake
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wlast  in  1  last write beat
s_axi_bvalid / s_axi_bready  out/in  1  B handshake
s_axi_bid  out  ID_WIDTH  echoed awid
s_axi_bresp  out  2  write response
s_axi_arvalid / s_axi_arready  in/out  1  AR handshake
s_axi_arid  in  ID_WIDTH  read ID
s_axi_araddr  in  ADDR_WIDTH  read start address
s_axi_arlen  in  8  beats-1
s_axi_arsize  in  3  beat size
s_axi_arburst  in  2  burst type
s_axi_rvalid / s_axi_rready  out/in  1  R handshake
s_axi_rid  out  ID_WIDTH  echoed arid
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  last read beat

Behaviour:
- Reset:
  - awready=1, arready=1; wready, bvalid, rvalid, rlast=0.
  - bresp, rresp, bid, rid, rdata=0.
  - Both FSMs go to IDLE. Memory contents are not reset.
  - Reset mid-burst abandons the burst. Beats already written stay written.
- Address mapping:
  - word index = addr[MEM_DEPTH_LOG2+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)].
  - A beat is out-of-range if any address bit above that field is set.
  - Low bits below the word index are ignored.
- Beat address: INCR adds DATA_WIDTH/8 per beat with ADDR_WIDTH wrap. FIXED holds the address. WRAP and reserved (2'b11) are treated as INCR and flagged SLVERR.
- Write FSM:
  - W_IDLE (awready=1): on AW handshake, latch id/addr/len/burst, clear beat counter and error flag, go to W_DATA.
  - W_DATA (wready=1): on each W handshake, write bytes where wstrb=1 if the beat is in range.
  - W_DATA to W_RESP: on the beat where counter==len. wlast mismatch (early or late) sets SLVERR but does not change the beat count.
  - W_RESP (bvalid=1): hold bid/bresp until bready, then go to W_IDLE. awready stays 0 until then.
- Read FSM:
  - R_IDLE (arready=1): on AR handshake, latch fields, go to R_FETCH.
  - R_FETCH: issue the synchronous array read, go to R_DATA.
  - R_DATA (rvalid=1): rdata/rresp/rid/rlast stay stable until rready. On handshake, go to R_IDLE if rlast, else advance the address and go to R_FETCH.
  - Latency: first rvalid 2 cycles after the AR handshake. Throughput: 1 beat per 2 cycles.
- Response codes, precedence DECERR > SLVERR > OKAY:
  - OKAY=00, SLVERR=10, DECERR=11.
  - Write: bresp is the sticky worst error over the whole burst.
  - Read: rresp is evaluated per beat, and rdata=0 on a DECERR beat.
  - Size mismatch (awsize/arsize != log2(DATA_WIDTH/8)) gives SLVERR. Data is still transferred full-width.
- Simultaneous read and write to the same word in one cycle: read returns the old data (read-first).
- Read and write channels never block each other.

Optional Feature:
- Macro: AXI_MEM_RAND_STALL_EN.
- Defined:
  - A 16-bit LFSR (seed 16'hACE1 at reset, advanced every cycle) gates awready, wready and arready.
  - The same LFSR delays assertion of bvalid and rvalid: each is asserted only when its LFSR tap bit is 1.
  - Once asserted, a valid holds until the handshake completes.
- Undefined: no LFSR logic; timing exactly as in Behaviour.

Decomposition:
- Package axi_mem_pkg: resp constants (RESP_OKAY/SLVERR/DECERR), burst constants (BURST_FIXED/INCR/WRAP), FSM state enums, helper function for next beat address.
- One sub-module: axi_mem_array, a simple dual-port RAM with byte-write port A and sync-read port B, read-first.

Test Plan:
- AW addr 0x100, len 3, INCR, wdata 0x11..0x44, wstrb all-ones, then AR addr 0x100 len 3 -> bresp OKAY; R beats 0x11,0x22,0x33,0x44, rlast on beat 4, rresp OKAY.
- Write 0xFFFF_FFFF_FFFF_FFFF then write 0x0 with wstrb 8'h0F to the same word, read back -> 0xFFFF_FFFF_0000_0000.
- AR addr 1<<15 (beyond 4K words x 8B), len 0 -> rresp 2'b11, rdata 0; same for AW -> bresp 2'b11, memory unchanged.
- AW len 3 with wlast asserted on beat 2 -> all 4 beats accepted, bresp 2'b10.
- Concurrent write burst and read burst with rready held low 5 cycles -> rdata/rlast stable while stalled; write completes independently; bid/rid echo awid=1/arid=0.
- rst pulsed mid-read-burst -> next cycle rvalid=0, arready=1; a new AR is then served normally.
